// File: rtl/enc_dec_mux_pkg.sv
// Shared constants and helpers for the enc_dec_mux utility block.
// Sizes, default width and output reset values live here so the top and the encoder agree.
package enc_dec_mux_pkg;

    localparam int unsigned DefaultW = 2;
    localparam int unsigned MaxW     = 5;

    // Reset values are wide enough for the largest legal W and are sliced at the use site.
    localparam logic [MaxW-1:0]       Out1RstVal    = '0;
    localparam logic                  Out1VldRstVal = 1'b0;
    localparam logic [(1<<MaxW)-1:0]  Out2RstVal    = '0;
    localparam logic                  Out3RstVal    = 1'b0;
    localparam logic                  OnehotRstVal  = 1'b0;

    function automatic int unsigned width_to_n(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/enc_dec_mux_prio_enc.sv
// Combinational N-to-W MSB-priority encoder with a valid flag.
// With ENC_DEC_MUX_ONEHOT_CHK_EN defined it also flags requests with two or more bits set.
module enc_dec_mux_prio_enc
    import enc_dec_mux_pkg::*;
#(
    parameter int unsigned W = DefaultW,
    localparam int unsigned N = width_to_n(W)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         vld
`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
    ,
    output logic         multi
`endif
);

    // Ascending scan: the last set bit seen wins, which gives MSB priority.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = i[W-1:0];
                vld = 1'b1;
            end
        end
    end

`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
    // A set bit arriving after an earlier one means popcount > 1.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/enc_dec_mux.sv
// Registered priority encoder, one-hot decoder and 2^W:1 mux sharing clk/rst/en, 1-cycle latency.
// Optional one-hot violation flag on in1 enabled by defining ENC_DEC_MUX_ONEHOT_CHK_EN.
module enc_dec_mux
    import enc_dec_mux_pkg::*;
#(
    parameter int unsigned W = DefaultW,
    localparam int unsigned N = width_to_n(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [W-1:0] select_lines,
    output logic [W-1:0] out1,
    output logic         out1_vld,
    output logic [N-1:0] out2,
    output logic         out3
`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
    ,
    output logic         onehot_err
`endif
);

    if (W < 1 || W > MaxW) begin : g_bad_width
        $error("enc_dec_mux: W must be in 1..5");
    end

    logic [W-1:0] enc_idx;
    logic         enc_vld;
    logic [N-1:0] dec_d;
    logic         mux_d;

    logic [W-1:0] out1_q;
    logic         out1_vld_q;
    logic [N-1:0] out2_q;
    logic         out3_q;

`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
    logic enc_multi;
    logic onehot_err_q;
`endif

    enc_dec_mux_prio_enc #(
        .W (W)
    ) u_prio_enc (
        .req   (in1),
        .idx   (enc_idx),
        .vld   (enc_vld)
`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
        ,
        .multi (enc_multi)
`endif
    );

    // Every code value maps to a real output bit, so the decode is never all-zero.
    always_comb begin
        dec_d        = '0;
        dec_d[in2]   = 1'b1;
    end

    assign mux_d = in3[select_lines];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_q     <= Out1RstVal[W-1:0];
            out1_vld_q <= Out1VldRstVal;
            out2_q     <= Out2RstVal[N-1:0];
            out3_q     <= Out3RstVal;
        end else if (en) begin
            out1_q     <= enc_idx;
            out1_vld_q <= enc_vld;
            out2_q     <= dec_d;
            out3_q     <= mux_d;
        end
    end

`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_err_q <= OnehotRstVal;
        end else if (en) begin
            onehot_err_q <= enc_multi;
        end
    end

    assign onehot_err = onehot_err_q;
`endif

    assign out1     = out1_q;
    assign out1_vld = out1_vld_q;
    assign out2     = out2_q;
    assign out3     = out3_q;

endmodule

// File: tb/tb_enc_dec_mux.sv
// Self-checking bench for enc_dec_mux (W=2): directed vector table, hand-written reset and
// enable sequences, then randomized stimulus against a behavioural model.
module tb_enc_dec_mux;

    localparam int unsigned W = 2;
    localparam int unsigned N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] in1;
    logic [W-1:0] in2;
    logic [N-1:0] in3;
    logic [W-1:0] select_lines;
    logic [W-1:0] out1;
    logic         out1_vld;
    logic [N-1:0] out2;
    logic         out3;
`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
    logic         onehot_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    enc_dec_mux #(
        .W (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in1          (in1),
        .in2          (in2),
        .in3          (in3),
        .select_lines (select_lines),
        .out1         (out1),
        .out1_vld     (out1_vld),
        .out2         (out2),
        .out3         (out3)
`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
        ,
        .onehot_err   (onehot_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] in1;
        logic [W-1:0] in2;
        logic [N-1:0] in3;
        logic [W-1:0] sel;
        logic [W-1:0] e_out1;
        logic         e_vld;
        logic [N-1:0] e_out2;
        logic         e_out3;
        logic         e_err;
    } vec_t;

    vec_t vecs [7];

    // Behavioural model state: what the outputs should show after the last edge.
    logic [W-1:0] m_out1;
    logic         m_vld;
    logic [N-1:0] m_out2;
    logic         m_out3;
    logic         m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e1, input logic ev,
                             input logic [N-1:0] e2, input logic e3, input logic ee);
        check({tag, ".out1"}, 32'(out1), 32'(e1));
        check({tag, ".out1_vld"}, 32'(out1_vld), 32'(ev));
        check({tag, ".out2"}, 32'(out2), 32'(e2));
        check({tag, ".out3"}, 32'(out3), 32'(e3));
`ifdef ENC_DEC_MUX_ONEHOT_CHK_EN
        check({tag, ".onehot_err"}, 32'(onehot_err), 32'(ee));
`else
        if (ee === 1'bx) $display("note: undefined expected err in %s", tag);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [W-1:0] b,
                         input logic [N-1:0] c, input logic [W-1:0] s);
        in1          = a;
        in2          = b;
        in3          = c;
        select_lines = s;
    endtask

    // Model computes each function straight from its definition.
    task automatic model_update();
        int hi;
        hi = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (in1[i] && hi < 0) hi = i;
        end
        m_vld  = (hi >= 0);
        m_out1 = (hi >= 0) ? W'(hi) : '0;
        m_out2 = N'(1) << in2;
        m_out3 = (in3 >> select_lines) & 1'b1;
        m_err  = ($countones(in1) > 1);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 2'd0, 4'b1010, 2'd0, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[1] = '{4'b0110, 2'd1, 4'b1010, 2'd1, 2'd2, 1'b1, 4'b0010, 1'b1, 1'b1};
        vecs[2] = '{4'b1111, 2'd2, 4'b1010, 2'd2, 2'd3, 1'b1, 4'b0100, 1'b0, 1'b1};
        vecs[3] = '{4'b0000, 2'd3, 4'b1010, 2'd3, 2'd0, 1'b0, 4'b1000, 1'b1, 1'b0};
        vecs[4] = '{4'b1000, 2'd0, 4'b0101, 2'd2, 2'd3, 1'b1, 4'b0001, 1'b1, 1'b0};
        vecs[5] = '{4'b0010, 2'd3, 4'b0101, 2'd0, 2'd1, 1'b1, 4'b1000, 1'b1, 1'b0};
        vecs[6] = '{4'b0100, 2'd2, 4'b0000, 2'd1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0};

        rst = 1'b1;
        en  = 1'b1;
        drive(4'b1111, 2'd3, 4'b1111, 2'd3);
        step();
        step();
        check_all("reset_hold", '0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed table: one edge per vector.
        foreach (vecs[k]) begin
            drive(vecs[k].in1, vecs[k].in2, vecs[k].in3, vecs[k].sel);
            step();
            check_all($sformatf("vec%0d", k), vecs[k].e_out1, vecs[k].e_vld, vecs[k].e_out2,
                      vecs[k].e_out3, vecs[k].e_err);
        end

        // Asynchronous reset mid-run with non-zero outputs.
        drive(4'b1111, 2'd3, 4'b1111, 2'd1);
        step();
        check_all("pre_rst", 2'd3, 1'b1, 4'b1000, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        check_all("rst_held", '0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(4'b0100, 2'd1, 4'b0000, 2'd0);
        step();
        check_all("rst_release", 2'd2, 1'b1, 4'b0010, 1'b0, 1'b0);

        // Enable hold for three cycles, then resume.
        drive(4'b0110, 2'd2, 4'b1000, 2'd3);
        step();
        check_all("hold_base", 2'd2, 1'b1, 4'b0100, 1'b1, 1'b1);
        en = 1'b0;
        drive(4'b0001, 2'd0, 4'b0000, 2'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_all($sformatf("hold%0d", c), 2'd2, 1'b1, 4'b0100, 1'b1, 1'b1);
        end
        en = 1'b1;
        step();
        check_all("resume", 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0);

        // Randomized run against the model.
        m_out1 = 2'd0; m_vld = 1'b1; m_out2 = 4'b0001; m_out3 = 1'b0; m_err = 1'b0;
        for (int t = 0; t < 300; t++) begin
            en = ($urandom_range(0, 3) != 0);
            drive(N'($urandom), W'($urandom), N'($urandom), W'($urandom));
            if ($urandom_range(0, 4) == 0) in1 = '0;
            if (en) model_update();
            step();
            check_all($sformatf("rand%0d", t), m_out1, m_vld, m_out2, m_out3, m_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/enc_dec_mux.md
Name: enc_dec_mux

Overview:
- Registered combination of three classic selection primitives:
  - a 2^W-to-W priority encoder;
  - a W-to-2^W one-hot decoder;
  - a 2^W:1 multiplexer.
- All three share one clock, one reset and one enable, and update their outputs together with a fixed 1-cycle latency.
- Sits as a utility leaf block for address/select generation and lane steering in datapath glue.

Parameters:
- W, default 2: select/code width. Encoder input, decoder output and mux data are N = 2^W bits wide.
- Legal W: 1..5.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  update enable; outputs hold when low
- in1  input  N  encoder request vector
- in2  input  W  decoder code
- in3  input  N  mux data vector
- select_lines  input  W  mux select
- out1  output  W  encoded index of in1
- out1_vld  output  1  high when in1 had any bit set
- out2  output  N  one-hot decode of in2
- out3  output  1  selected bit in3[select_lines]

Behaviour:
- Reset:
  - rst high asynchronously forces out1=0, out1_vld=0, out2=0, out3=0.
  - Outputs stay at these values while rst is high.
  - Reset release is synchronous in effect: the first update happens on the first rising clk edge with rst low and en high.
- Latency and enable:
  - All outputs are registered, with 1 cycle from input to output.
  - On a rising clk edge with en=1, all registers load the new function values.
  - With en=0, all registers hold.
  - Inputs are sampled only at the clock edge; there is no handshake.
- Encoder:
  - out1 = index of the highest-numbered set bit of in1 (MSB priority).
  - Examples (W=2): 0001->00, 0010->01, 0100->10, 1000->11, 0110->10, 1111->11.
  - in1 all zero: out1=0 and out1_vld=0. Otherwise out1_vld=1.
- Decoder:
  - out2 has exactly bit in2 set, all other bits clear.
  - Examples (W=2): 00->0001, 11->1000.
  - Every in2 value is legal, so there is never an all-zero decode after reset.
- Mux:
  - out3 = in3[select_lines].
  - Every select_lines value is legal; no out-of-range case exists.
- The three functions are independent: changing one input group never affects the other outputs.
- X/Z on inputs is not required to be handled; outputs are defined only for 0/1 inputs.

Optional Feature:
- Macro ENC_DEC_MUX_ONEHOT_CHK_EN.
- When defined:
  - adds output port onehot_err (1 bit), registered with the same en/rst rules as the other outputs, reset 0;
  - onehot_err is set to 1 when in1 has two or more bits set, else 0;
  - encoder output is still the MSB-priority result.
- When not defined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package enc_dec_mux_pkg holds:
  - default W constant;
  - function clog-free N derivation (N = 1<<W);
  - reset-value constants for out1/out2/out3.
- One natural sub-module, prio_enc:
  - purely combinational N-to-W MSB-priority encoder with vld output;
  - reused by the optional one-hot check (popcount>1 derived alongside).
- Decoder, mux and output registers stay in the top.

Test Plan:
- Reset check: assert rst mid-run with outputs non-zero -> all outputs 0 immediately, without waiting for clk; release then en=1, in1=0100 -> next edge out1=10, out1_vld=1.
- Encoder priority: in1=0001 / 0110 / 1111 / 0000 -> out1=00/10/11/00 and out1_vld=1/1/1/0, each one cycle later.
- Decoder sweep: in2=00,01,10,11 -> out2=0001,0010,0100,1000.
- Mux sweep: in3=1010, select_lines=0..3 -> out3=0,1,0,1; then in3=0101 with select_lines=2 -> out3=1.
- Enable hold: en=0, change all inputs -> outputs unchanged for 3 cycles; en=1 -> new values after one edge.
- With ENC_DEC_MUX_ONEHOT_CHK_EN defined: in1=0110 -> onehot_err=1, out1=10; in1=0100 -> onehot_err=0.
